cache_ctrl_l1: RTL and testbench

Sequencing controller between a CPU-side request port and the `cache_l1_2way` L1 instance, with a handshaked backing memory behind it.
- Reads: lookup; on hit, return data; on miss, line refill from memory, then return.
- Writes: write-through, no-allocate (cache updated only on hit).
- Way selection and LRU stay inside the cache; this block only drives its `addr`/`wren`/`data` and samples `hit`/`q`.

---
 rtl/cache_pkg.sv | 38 +++
 rtl/cache_stat_ctr.sv | 22 ++
 rtl/cache_ctrl_l1.sv | 205 ++++++++++++++++++++
 tb/tb_cache_ctrl_l1.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared L1 cache definitions: default widths, address field
// layout and controller state encoding.
package cache_pkg;

    localparam int CACHE_ADDR_W   = 7;
    localparam int CACHE_DATA_W   = 16;
    localparam int CACHE_OFFSET_W = 1;
    localparam int CACHE_INDEX_W  = 2;
    localparam int CACHE_TAG_W    =
        CACHE_ADDR_W - CACHE_INDEX_W - CACHE_OFFSET_W;

    // Address = {tag, index, offset}
    localparam int CACHE_OFFSET_LSB = 0;
    localparam int CACHE_INDEX_LSB  = CACHE_OFFSET_W;
    localparam int CACHE_TAG_LSB    =
        CACHE_OFFSET_W + CACHE_INDEX_W;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_FILL_RD = 3'd3;
    localparam logic [2:0] ST_FILL_WR = 3'd4;
    localparam logic [2:0] ST_HIT_WR  = 3'd5;
    localparam logic [2:0] ST_MEM_WR  = 3'd6;
    localparam logic [2:0] ST_RESP    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LOOKUP  = ST_LOOKUP,
        S_CHECK   = ST_CHECK,
        S_FILL_RD = ST_FILL_RD,
        S_FILL_WR = ST_FILL_WR,
        S_HIT_WR  = ST_HIT_WR,
        S_MEM_WR  = ST_MEM_WR,
        S_RESP    = ST_RESP
    } ctrl_state_t;

endpackage

// File: rtl/cache_stat_ctr.sv
// Saturating 16-bit event counter.
// Ports: clk, reset (async active-low), i_inc, o_count.
module cache_stat_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_ctrl_l1.sv
// L1 controller: CPU port <-> cache_l1_2way <-> handshaked memory.
// Reads refill on miss; writes are write-through, no-allocate.
// Ports: clk, reset (async active-low); cpu_req/we/addr/wdata in,
// cpu_ready/rdata out; cache_addr/wren/data out, cache_hit/q in;
// mem_req/we/addr/wdata out, mem_ack/rdata in.
// Optional: CACHE_CTRL_STATS_EN adds stat_hits/stat_misses.
module cache_ctrl_l1
    import cache_pkg::*;
#(
    parameter int ADDR_W   = CACHE_ADDR_W,
    parameter int DATA_W   = CACHE_DATA_W,
    parameter int OFFSET_W = CACHE_OFFSET_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_wren,
    output logic [DATA_W-1:0] cache_data,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses
`endif
);

    localparam logic [OFFSET_W-1:0] K_LAST = '1;

    ctrl_state_t r_state;
    ctrl_state_t w_next;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [OFFSET_W-1:0] r_k;
    logic [DATA_W-1:0]   r_fill;
    logic [DATA_W-1:0]   r_rdata;

    logic [ADDR_W-OFFSET_W-1:0] w_line;
    logic [OFFSET_W-1:0]        w_off;
    logic [ADDR_W-1:0]          w_fill_addr;

    assign w_line      = r_addr[ADDR_W-1:OFFSET_W];
    assign w_off       = r_addr[OFFSET_W-1:0];
    assign w_fill_addr = {w_line, r_k};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_k     <= '0;
            r_fill  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                    end
                end
                S_CHECK: begin
                    if (!r_we && cache_hit) begin
                        r_rdata <= cache_q;
                    end
                    if (!r_we && !cache_hit) begin
                        r_k <= '0;
                    end
                end
                S_FILL_RD: begin
                    if (mem_ack) begin
                        r_fill <= mem_rdata;
                    end
                end
                S_FILL_WR: begin
                    // Requested word may sit anywhere in the line
                    if (r_k == w_off) begin
                        r_rdata <= r_fill;
                    end
                    if (r_k != K_LAST) begin
                        r_k <= r_k + OFFSET_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        cpu_ready  = 1'b0;
        cache_addr = '0;
        cache_wren = 1'b0;
        cache_data = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                cache_addr = r_addr;
                w_next     = S_CHECK;
            end
            S_CHECK: begin
                cache_addr = r_addr;
                unique case ({r_we, cache_hit})
                    2'b01:   w_next = S_RESP;
                    2'b00:   w_next = S_FILL_RD;
                    2'b11:   w_next = S_HIT_WR;
                    default: w_next = S_MEM_WR;
                endcase
            end
            S_FILL_RD: begin
                mem_req  = 1'b1;
                mem_addr = w_fill_addr;
                if (mem_ack) begin
                    w_next = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                cache_wren = 1'b1;
                cache_addr = w_fill_addr;
                cache_data = r_fill;
                if (r_k == K_LAST) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_FILL_RD;
                end
            end
            S_HIT_WR: begin
                cache_wren = 1'b1;
                cache_addr = r_addr;
                cache_data = r_wdata;
                w_next     = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (mem_ack) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                cpu_ready = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign cpu_rdata = r_rdata;

`ifdef CACHE_CTRL_STATS_EN
    logic w_hit_ev;
    logic w_miss_ev;

    assign w_hit_ev  = (r_state == S_CHECK) && cache_hit;
    assign w_miss_ev = (r_state == S_CHECK) && !cache_hit;

    cache_stat_ctr u_hits (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_hit_ev),
        .o_count (stat_hits)
    );

    cache_stat_ctr u_misses (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_miss_ev),
        .o_count (stat_misses)
    );
`endif

endmodule

// File: tb/tb_cache_ctrl_l1.sv
// Directed bench for cache_ctrl_l1 with behavioural cache
// and handshaked memory models.
module tb_cache_ctrl_l1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [6:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic [6:0]  cache_addr;
    logic        cache_wren;
    logic [15:0] cache_data;
    logic        cm_hit;
    logic [15:0] cm_q;
    logic        mem_req;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'hDEAD;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
`endif

    always #5 clk = ~clk;

    cache_ctrl_l1 dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cache_addr (cache_addr),
        .cache_wren (cache_wren),
        .cache_data (cache_data),
        .cache_hit  (cm_hit),
        .cache_q    (cm_q),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    // Cache model: registered lookup, one-cycle read latency
    logic [15:0] cm_data [128];
    logic        cm_valid[128];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) cm_valid[i] <= 1'b0;
            cm_hit <= 1'b0;
            cm_q   <= '0;
        end else begin
            cm_hit <= cm_valid[cache_addr];
            cm_q   <= cm_data[cache_addr];
            if (cache_wren) begin
                cm_data[cache_addr]  <= cache_data;
                cm_valid[cache_addr] <= 1'b1;
            end
        end
    end

    // Memory responder and bus monitor
    logic [15:0] mem_arr [128];
    int          mem_delay = 0;
    int          wait_cnt = 0;
    bit          spurious = 0;
    int          wr_cnt = 0;
    logic [6:0]  last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    logic [6:0]  fill_log[$];
    int          req_cycles = 0;
    int          unstable = 0;
    int          wren_cnt = 0;
    int          rdy_cnt = 0;
    logic        p_req = 0;
    logic        p_ack = 0;
    logic        p_we = 0;
    logic [6:0]  p_addr = '0;
    logic [15:0] p_wdata = '0;

    always @(negedge clk) begin
        if (mem_req) begin
            if (wait_cnt >= mem_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    wr_cnt++;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                    mem_rdata = 16'hDEAD;
                end else begin
                    mem_rdata = mem_arr[mem_addr];
                    fill_log.push_back(mem_addr);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'hDEAD;
                wait_cnt++;
            end
            if (p_req && !p_ack &&
                (mem_addr !== p_addr || mem_we !== p_we ||
                 mem_wdata !== p_wdata))
                unstable++;
            req_cycles++;
        end else begin
            mem_ack   = spurious;
            mem_rdata = 16'hDEAD;
            wait_cnt  = 0;
        end
        p_req   = mem_req;
        p_ack   = mem_ack;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        if (cache_wren) wren_cnt++;
        if (cpu_ready) rdy_cnt++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we,
                          input logic [6:0] a,
                          input logic [15:0] d,
                          output int lat);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) break;
        end
        chk("ready_seen", 32'(cpu_ready), 32'd1);
        @(negedge clk);
        chk("ready_pulse", 32'(cpu_ready), 32'd0);
    endtask

    int lat;
    int w0, r0, q0, c0;
    int seen;

    initial begin
        for (int i = 0; i < 128; i++) mem_arr[i] = '0;
        mem_arr[7'h0B] = 16'h1234;
        mem_arr[7'h12] = 16'h5555;
        mem_arr[7'h13] = 16'h6666;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_wren", 32'(cache_wren), 32'd0);
        chk("rst_caddr", 32'(cache_addr), 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        reset = 1'b1;

        // 1: write miss
        w0 = wren_cnt; r0 = rdy_cnt; c0 = wr_cnt;
        do_req(1'b1, 7'h0A, 16'hABCD, lat);
        chk("wm_lat", 32'(lat), 32'd4);
        chk("wm_wren", 32'(wren_cnt - w0), 32'd0);
        chk("wm_rdy", 32'(rdy_cnt - r0), 32'd1);
        chk("wm_wrcnt", 32'(wr_cnt - c0), 32'd1);
        chk("wm_addr", 32'(last_wr_addr), 32'h0A);
        chk("wm_data", 32'(last_wr_data), 32'hABCD);

        // 2: read miss with line refill
        fill_log.delete();
        w0 = wren_cnt;
        do_req(1'b0, 7'h0A, 16'h0, lat);
        chk("rm_lat", 32'(lat), 32'd7);
        chk("rm_rdata", 32'(cpu_rdata), 32'hABCD);
        chk("rm_nfill", 32'(fill_log.size()), 32'd2);
        if (fill_log.size() == 2) begin
            chk("rm_fill0", 32'(fill_log[0]), 32'h0A);
            chk("rm_fill1", 32'(fill_log[1]), 32'h0B);
        end
        chk("rm_wren", 32'(wren_cnt - w0), 32'd2);

        // 3: read hit on the other word
        q0 = req_cycles;
        do_req(1'b0, 7'h0B, 16'h0, lat);
        chk("rh_lat", 32'(lat), 32'd3);
        chk("rh_rdata", 32'(cpu_rdata), 32'h1234);
        chk("rh_memreq", 32'(req_cycles - q0), 32'd0);

        // 4: write hit, then read it back
        w0 = wren_cnt; c0 = wr_cnt;
        do_req(1'b1, 7'h0A, 16'hBEEF, lat);
        chk("wh_lat", 32'(lat), 32'd5);
        chk("wh_wren", 32'(wren_cnt - w0), 32'd1);
        chk("wh_wrcnt", 32'(wr_cnt - c0), 32'd1);
        chk("wh_mdata", 32'(last_wr_data), 32'hBEEF);
        chk("wh_hold", 32'(cpu_rdata), 32'h1234);
        q0 = req_cycles;
        do_req(1'b0, 7'h0A, 16'h0, lat);
        chk("wh_rlat", 32'(lat), 32'd3);
        chk("wh_rdata", 32'(cpu_rdata), 32'hBEEF);
        chk("wh_rmem", 32'(req_cycles - q0), 32'd0);

        // 5: memory stall and spurious ack
        mem_delay = 5;
        q0 = req_cycles; unstable = 0;
        do_req(1'b1, 7'h20, 16'h7777, lat);
        chk("st_lat", 32'(lat), 32'd9);
        chk("st_reqcyc", 32'(req_cycles - q0), 32'd6);
        chk("st_stable", 32'(unstable), 32'd0);
        chk("st_mdata", 32'(mem_arr[7'h20]), 32'h7777);
        q0 = req_cycles; r0 = rdy_cnt;
        spurious = 1;
        repeat (3) @(negedge clk);
        spurious = 0;
        @(negedge clk);
        chk("sp_memreq", 32'(req_cycles - q0), 32'd0);
        chk("sp_rdy", 32'(rdy_cnt - r0), 32'd0);
        chk("sp_req", 32'(mem_req), 32'd0);

        // 6: reset during refill of 0x12
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h12;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_addr = '0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1;
                break;
            end
        end
        chk("rr_fillrd", 32'(seen), 32'd1);
        chk("rr_faddr", 32'(mem_addr), 32'h12);
        #2 reset = 1'b0;
        #1;
        chk("rr_req", 32'(mem_req), 32'd0);
        chk("rr_maddr", 32'(mem_addr), 32'd0);
        chk("rr_rdy", 32'(cpu_ready), 32'd0);
        chk("rr_rdata", 32'(cpu_rdata), 32'd0);
        chk("rr_wren", 32'(cache_wren), 32'd0);
        chk("rr_caddr", 32'(cache_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_delay = 0;
        fill_log.delete();
        do_req(1'b0, 7'h12, 16'h0, lat);
        chk("rr_lat", 32'(lat), 32'd7);
        chk("rr_data", 32'(cpu_rdata), 32'h5555);
        chk("rr_nfill", 32'(fill_log.size()), 32'd2);
        if (fill_log.size() == 2) begin
            chk("rr_fill0", 32'(fill_log[0]), 32'h12);
            chk("rr_fill1", 32'(fill_log[1]), 32'h13);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
